// File: rtl/cntrl_spi_pkg.sv
// Register map, ID default and shared types for the SPI-attached control register block.
// Also imported by spi_slave users so both sides agree on addresses.
package cntrl_spi_pkg;

    localparam logic [6:0] CNTRL_SPI_REG_ID                = 7'h00;
    localparam logic [6:0] CNTRL_SPI_REG_RST_CNTRL         = 7'h01;
    localparam logic [6:0] CNTRL_SPI_REG_IRQ_CNTRL_STATUS  = 7'h02;
    localparam logic [6:0] CNTRL_SPI_REG_LED_CNTRL         = 7'h03;
    localparam logic [6:0] CNTRL_SPI_REG_ADC_DPRAM_CNTRL   = 7'h10;
    localparam logic [6:0] CNTRL_SPI_REG_ADC_DPRAM_ADDR    = 7'h11;
    localparam logic [6:0] CNTRL_SPI_REG_ADC_DPRAM_DATA    = 7'h12;
    localparam logic [6:0] CNTRL_SPI_REG_DDC_CNTRL         = 7'h20;
    localparam logic [6:0] CNTRL_SPI_REG_DDC_LO_FREQ       = 7'h21;
    localparam logic [6:0] CNTRL_SPI_REG_AUDIO_I2S_MUX_SEL = 7'h30;

    localparam logic [31:0] CNTRL_SPI_ID_DEFAULT = 32'h1C0A_0001;

    localparam int CNTRL_SPI_NUM_RST = 8;
    localparam int CNTRL_SPI_NUM_IRQ = 8;

    // Layout of the IRQ_CNTRL_STATUS register low half-word.
    typedef struct packed {
        logic [CNTRL_SPI_NUM_IRQ-1:0] enable;
        logic [CNTRL_SPI_NUM_IRQ-1:0] status;
    } irq_reg_t;

endpackage

// File: rtl/pulse_stretch.sv
// Turns a one-cycle trigger into a pulse CYCLES clocks long, starting the cycle after
// the trigger; a new trigger while active restarts the full length.
module pulse_stretch #(
    parameter int CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_trig,
    output logic o_pulse
);

    localparam int CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_trig) begin
            r_cnt <= CW'(CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_pulse = (r_cnt != '0);

endmodule

// File: rtl/spi_reg_ctrl.sv
// Control/status register file behind the SPI slave: ID, software resets, IRQ
// status/enable, LEDs, ADC DPRAM window, DDC and audio mux controls.
module spi_reg_ctrl
    import cntrl_spi_pkg::*;
#(
    parameter logic [31:0] ID_VALUE   = CNTRL_SPI_ID_DEFAULT,
    parameter int          DPRAM_AW   = 10,
    parameter int          RST_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          addr,
    input  logic [31:0]         data_out,
    output logic [31:0]         data_in,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [7:0]          irq_src,
    output logic                irq,
    output logic [7:0]          sw_rst,
    output logic [3:0]          led,
    output logic [DPRAM_AW-1:0] dpram_rd_addr,
    input  logic [31:0]         dpram_rd_data,
    output logic [7:0]          dpram_ctrl,
    output logic [31:0]         ddc_ctrl,
    output logic [31:0]         ddc_lo_freq,
    output logic [1:0]          i2s_mux_sel
);

    // Access protocol: wr_en / rd_en are single-clk strobes qualified by addr; there is
    // no back-pressure. A write lands on that edge; read data is combinational and is
    // taken by the slave while rd_en is high. With both strobes high the write wins and
    // the read has no side effects.

    irq_reg_t            r_irq;
    logic [7:0]          r_irq_src_d;
    logic                r_irq_out;
    logic [3:0]          r_led;
    logic [7:0]          r_dpram_ctrl;
    logic [DPRAM_AW-1:0] r_dpram_addr;
    logic [31:0]         r_ddc_ctrl;
    logic [31:0]         r_ddc_lo_freq;
    logic [1:0]          r_i2s_mux_sel;

    logic                w_wr_rst;
    logic                w_wr_irq;
    logic                w_rd_dpram;
    logic [7:0]          w_irq_clr;
    logic [7:0]          w_irq_rise;
    logic [7:0]          w_rst_trig;
    logic [7:0]          w_sw_rst;

    assign w_wr_rst   = wr_en && (addr == CNTRL_SPI_REG_RST_CNTRL);
    assign w_wr_irq   = wr_en && (addr == CNTRL_SPI_REG_IRQ_CNTRL_STATUS);
    assign w_rd_dpram = rd_en && !wr_en && (addr == CNTRL_SPI_REG_ADC_DPRAM_DATA);
    assign w_irq_clr  = w_wr_irq ? data_out[7:0] : 8'h00;
    assign w_irq_rise = irq_src & ~r_irq_src_d;
    assign w_rst_trig = w_wr_rst ? data_out[7:0] : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq         <= '0;
            r_irq_src_d   <= '0;
            r_irq_out     <= 1'b0;
            r_led         <= '0;
            r_dpram_ctrl  <= '0;
            r_dpram_addr  <= '0;
            r_ddc_ctrl    <= '0;
            r_ddc_lo_freq <= '0;
            r_i2s_mux_sel <= '0;
        end else begin
            r_irq_src_d   <= irq_src;
            // Set has priority over the W1C clear so a coincident event is not lost.
            r_irq.status  <= (r_irq.status & ~w_irq_clr) | w_irq_rise;
            r_irq_out     <= |(r_irq.status & r_irq.enable);
            if (w_wr_irq) begin
                r_irq.enable <= data_out[15:8];
            end
            if (wr_en) begin
                case (addr)
                    CNTRL_SPI_REG_LED_CNTRL:         r_led         <= data_out[3:0];
                    CNTRL_SPI_REG_ADC_DPRAM_CNTRL:   r_dpram_ctrl  <= data_out[7:0];
                    CNTRL_SPI_REG_ADC_DPRAM_ADDR:    r_dpram_addr  <= data_out[DPRAM_AW-1:0];
                    CNTRL_SPI_REG_DDC_CNTRL:         r_ddc_ctrl    <= data_out;
                    CNTRL_SPI_REG_DDC_LO_FREQ:       r_ddc_lo_freq <= data_out;
                    CNTRL_SPI_REG_AUDIO_I2S_MUX_SEL: r_i2s_mux_sel <= data_out[1:0];
                    default: ;
                endcase
            end else if (w_rd_dpram && r_dpram_ctrl[0]) begin
                r_dpram_addr <= r_dpram_addr + DPRAM_AW'(1);
            end
        end
    end

    for (genvar g = 0; g < CNTRL_SPI_NUM_RST; g++) begin : g_rst
        pulse_stretch #(
            .CYCLES (RST_CYCLES)
        ) u_pulse_stretch (
            .i_clk   (clk),
            .i_reset (reset),
            .i_trig  (w_rst_trig[g]),
            .o_pulse (w_sw_rst[g])
        );
    end

    always_comb begin
        data_in = '0;
        case (addr)
            CNTRL_SPI_REG_ID:                data_in = ID_VALUE;
            CNTRL_SPI_REG_RST_CNTRL:         data_in[7:0] = w_sw_rst;
            CNTRL_SPI_REG_IRQ_CNTRL_STATUS:  data_in[15:0] = r_irq;
            CNTRL_SPI_REG_LED_CNTRL:         data_in[3:0] = r_led;
            CNTRL_SPI_REG_ADC_DPRAM_CNTRL:   data_in[7:0] = r_dpram_ctrl;
            CNTRL_SPI_REG_ADC_DPRAM_ADDR:    data_in[DPRAM_AW-1:0] = r_dpram_addr;
            CNTRL_SPI_REG_ADC_DPRAM_DATA:    data_in = dpram_rd_data;
            CNTRL_SPI_REG_DDC_CNTRL:         data_in = r_ddc_ctrl;
            CNTRL_SPI_REG_DDC_LO_FREQ:       data_in = r_ddc_lo_freq;
            CNTRL_SPI_REG_AUDIO_I2S_MUX_SEL: data_in[1:0] = r_i2s_mux_sel;
            default:                         data_in = '0;
        endcase
    end

    assign irq           = r_irq_out;
    assign sw_rst        = w_sw_rst;
    assign led           = r_led;
    assign dpram_rd_addr = r_dpram_addr;
    assign dpram_ctrl    = r_dpram_ctrl;
    assign ddc_ctrl      = r_ddc_ctrl;
    assign ddc_lo_freq   = r_ddc_lo_freq;
    assign i2s_mux_sel   = r_i2s_mux_sel;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed scenarios plus random register traffic, all checked
// against an architectural register model; read data goes through an expected queue.
module tb_spi_reg_ctrl;

    localparam logic [31:0] ID  = 32'h1C0A_0001;
    localparam int          AW  = 10;
    localparam int          RC  = 16;
    localparam int          DPW = 1 << AW;

    logic          clk;
    logic          reset;
    logic [6:0]    addr;
    logic [31:0]   data_out;
    logic [31:0]   data_in;
    logic          wr_en;
    logic          rd_en;
    logic [7:0]    irq_src;
    logic          irq;
    logic [7:0]    sw_rst;
    logic [3:0]    led;
    logic [AW-1:0] dpram_rd_addr;
    logic [31:0]   dpram_rd_data;
    logic [7:0]    dpram_ctrl;
    logic [31:0]   ddc_ctrl;
    logic [31:0]   ddc_lo_freq;
    logic [1:0]    i2s_mux_sel;

    spi_reg_ctrl #(
        .ID_VALUE   (ID),
        .DPRAM_AW   (AW),
        .RST_CYCLES (RC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .addr          (addr),
        .data_out      (data_out),
        .data_in       (data_in),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .irq_src       (irq_src),
        .irq           (irq),
        .sw_rst        (sw_rst),
        .led           (led),
        .dpram_rd_addr (dpram_rd_addr),
        .dpram_rd_data (dpram_rd_data),
        .dpram_ctrl    (dpram_ctrl),
        .ddc_ctrl      (ddc_ctrl),
        .ddc_lo_freq   (ddc_lo_freq),
        .i2s_mux_sel   (i2s_mux_sel)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment: ADC DPRAM, 1 clk read latency ----------------
    logic [31:0] mem [DPW];
    always @(posedge clk) dpram_rd_data <= mem[dpram_rd_addr];

    // ---------------- counters and scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];
    logic [6:0]  exp_addr_q [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- architectural reference model ----------------
    logic [7:0]  m_st, m_en, m_src_prev, m_dp_ctrl;
    logic [3:0]  m_led;
    logic [31:0] m_ddc, m_lo;
    logic [1:0]  m_i2s;
    logic        m_irq;
    int          m_dp_addr;
    int          m_left [8];

    function automatic void model_reset();
        m_st = '0; m_en = '0; m_src_prev = '0; m_dp_ctrl = '0; m_led = '0;
        m_ddc = '0; m_lo = '0; m_i2s = '0; m_irq = 1'b0; m_dp_addr = 0;
        for (int i = 0; i < 8; i++) m_left[i] = 0;
    endfunction

    function automatic logic [7:0] m_rst_bits();
        logic [7:0] b = '0;
        for (int i = 0; i < 8; i++) b[i] = (m_left[i] > 0);
        return b;
    endfunction

    function automatic logic [31:0] model_read(input logic [6:0] a);
        case (a)
            7'h00:   return ID;
            7'h01:   return {24'h0, m_rst_bits()};
            7'h02:   return {16'h0, m_en, m_st};
            7'h03:   return {28'h0, m_led};
            7'h10:   return {24'h0, m_dp_ctrl};
            7'h11:   return 32'(m_dp_addr);
            7'h12:   return mem[m_dp_addr];
            7'h20:   return m_ddc;
            7'h21:   return m_lo;
            7'h30:   return {30'h0, m_i2s};
            default: return 32'h0;
        endcase
    endfunction

    // Architectural effect of one clock edge with the given bus inputs.
    function automatic void model_edge(input logic wr, input logic rd, input logic [6:0] a,
                                       input logic [31:0] d, input logic [7:0] src);
        logic       nirq;
        logic [7:0] clr;
        nirq = |(m_st & m_en);
        clr  = (wr && a == 7'h02) ? d[7:0] : 8'h00;
        m_st = (m_st & ~clr) | (src & ~m_src_prev);
        m_src_prev = src;
        for (int i = 0; i < 8; i++) begin
            if (wr && a == 7'h01 && d[i]) m_left[i] = RC;
            else if (m_left[i] > 0)       m_left[i] = m_left[i] - 1;
        end
        if (wr) begin
            case (a)
                7'h02: m_en      = d[15:8];
                7'h03: m_led     = d[3:0];
                7'h10: m_dp_ctrl = d[7:0];
                7'h11: m_dp_addr = int'(d[AW-1:0]);
                7'h20: m_ddc     = d;
                7'h21: m_lo      = d;
                7'h30: m_i2s     = d[1:0];
                default: ;
            endcase
        end else if (rd && a == 7'h12 && m_dp_ctrl[0]) begin
            m_dp_addr = (m_dp_addr + 1) % DPW;
        end
        m_irq = nirq;
    endfunction

    task automatic check_outputs();
        check("sw_rst",        32'(sw_rst),        32'(m_rst_bits()));
        check("irq",           32'(irq),           32'(m_irq));
        check("led",           32'(led),           32'(m_led));
        check("dpram_ctrl",    32'(dpram_ctrl),    32'(m_dp_ctrl));
        check("dpram_rd_addr", 32'(dpram_rd_addr), 32'(m_dp_addr));
        check("ddc_ctrl",      ddc_ctrl,           m_ddc);
        check("ddc_lo_freq",   ddc_lo_freq,        m_lo);
        check("i2s_mux_sel",   32'(i2s_mux_sel),   32'(m_i2s));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sw_rst"},   32'(sw_rst),        32'h0);
        check({tag, "_irq"},      32'(irq),           32'h0);
        check({tag, "_led"},      32'(led),           32'h0);
        check({tag, "_dp_addr"},  32'(dpram_rd_addr), 32'h0);
        check({tag, "_dp_ctrl"},  32'(dpram_ctrl),    32'h0);
        check({tag, "_ddc"},      ddc_ctrl,           32'h0);
        check({tag, "_lo"},       ddc_lo_freq,        32'h0);
        check({tag, "_i2s"},      32'(i2s_mux_sel),   32'h0);
    endtask

    // ---------------- monitor: pops expected read data whenever a read strobe is seen ----------------
    always @(negedge clk) begin
        if (!reset && rd_en) begin
            if (exp_q.size() == 0) begin
                check("read_unexpected", data_in, 32'hDEAD_BEEF ^ data_in ^ 32'h1);
            end else begin
                check($sformatf("read_%02h", exp_addr_q.pop_front()), data_in, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks (entered 1 time unit after a rising edge) ----------------
    task automatic cycle(input logic wr, input logic rd, input logic [6:0] a,
                         input logic [31:0] d, input logic [7:0] src);
        wr_en = wr; rd_en = rd; addr = a; data_out = d; irq_src = src;
        if (rd) begin
            exp_q.push_back(model_read(a));
            exp_addr_q.push_back(a);
        end
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge(wr, rd, a, d, src);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, addr, 32'h0, irq_src);
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b0, a, d, irq_src);
    endtask

    task automatic rd(input logic [6:0] a);
        cycle(1'b0, 1'b1, a, 32'h0, irq_src);
    endtask

    task automatic peek(input string nm, input logic [6:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(nm, data_in, exp);
    endtask

    // ---------------- stimulus ----------------
    logic [6:0] addr_tbl [10] = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h10,
                                  7'h11, 7'h12, 7'h20, 7'h21, 7'h30};

    initial begin
        int hi;
        logic [6:0] a;
        logic w, r;

        for (int i = 0; i < DPW; i++) mem[i] = $urandom;
        reset = 1'b1; addr = 7'h00; data_out = '0; wr_en = 1'b0; rd_en = 1'b0; irq_src = '0;
        model_reset();

        #3;
        check_all_zero("reset");
        check("id_in_reset", data_in, ID);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
        rd(7'h00); rd(7'h01); rd(7'h02); rd(7'h11); rd(7'h20);

        // Software reset pulse: bits 0 and 2 for exactly RC cycles.
        wr(7'h01, 32'h0000_0005);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (sw_rst == 8'h05) hi++;
            else check("sw_rst_other", 32'(sw_rst), 32'h0);
            if (k == 3) peek("rd_rst_during_pulse", 7'h01, 32'h0000_0005);
            cycle(1'b0, k == 5, 7'h01, 32'h0, 8'h00);
        end
        check("sw_rst_pulse_len", 32'(hi), 32'd16);

        // Rewrite of an active bit restarts its count.
        wr(7'h01, 32'h0000_0001);
        idle(9);
        wr(7'h01, 32'h0000_0001);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (sw_rst[0]) hi++;
            idle(1);
        end
        check("sw_rst_restart_len", 32'(hi), 32'd16);

        // IRQ: enable, edge, W1C clear, edge coinciding with clear.
        wr(7'h02, 32'h0000_0100);
        cycle(1'b0, 1'b0, 7'h02, 32'h0, 8'h01);
        peek("irq_status_set", 7'h02, 32'h0000_0101);
        check("irq_before_latency", 32'(irq), 32'h0);
        idle(1);
        check("irq_high", 32'(irq), 32'h1);
        wr(7'h02, 32'h0000_0001);
        idle(1);
        check("irq_low_after_clear", 32'(irq), 32'h0);
        cycle(1'b0, 1'b0, 7'h02, 32'h0, 8'h00);
        cycle(1'b0, 1'b0, 7'h02, 32'h0, 8'h01);
        cycle(1'b0, 1'b0, 7'h02, 32'h0, 8'h00);
        cycle(1'b1, 1'b0, 7'h02, 32'h0000_0101, 8'h01);
        peek("irq_edge_beats_clear", 7'h02, 32'h0000_0101);

        // DPRAM window with auto-increment across the wrap.
        wr(7'h10, 32'h1);
        wr(7'h11, 32'h3FE);
        for (int k = 0; k < 3; k++) begin
            addr = 7'h12;
            idle(2);
            peek($sformatf("dpram_word_%0d", k), 7'h12, mem[(32'h3FE + k) % DPW]);
            rd(7'h12);
        end
        peek("dpram_addr_after", 7'h11, 32'h0000_0001);

        // DDC control and ignored writes.
        wr(7'h20, 32'hDDC0_AA0C);
        peek("ddc_readback", 7'h20, 32'hDDC0_AA0C);
        check("ddc_ctrl_out", ddc_ctrl, 32'hDDC0_AA0C);
        wr(7'h00, 32'hFFFF_FFFF);
        wr(7'h7F, 32'hFFFF_FFFF);
        peek("id_after_write", 7'h00, ID);
        peek("unmapped_7f", 7'h7F, 32'h0);

        // Random register traffic, including simultaneous read/write strobes.
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 11) == 0) ? 7'($urandom) : addr_tbl[$urandom_range(0, 9)];
            w = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 2) == 0);
            if (r && a == 7'h12) begin
                addr = a;
                idle(2);
            end
            cycle(w, r, a, $urandom, 8'($urandom));
        end

        // Asynchronous reset during a pulse with irq high.
        wr(7'h03, 32'hF);
        cycle(1'b1, 1'b0, 7'h02, 32'h0000_FFFF, 8'h00);
        cycle(1'b0, 1'b0, 7'h02, 32'h0, 8'h02);
        idle(1);
        wr(7'h01, 32'h0000_00FF);
        check("pre_reset_sw_rst", 32'(sw_rst), 32'h0000_00FF);
        check("pre_reset_irq", 32'(irq), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        peek("rst_cntrl_in_reset", 7'h01, 32'h0);
        model_reset();
        irq_src = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (sw_rst != 8'h00) hi++;
            idle(1);
        end
        check("no_pulse_resume", 32'(hi), 32'h0);

        idle(2);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 The block SHALL have parameter ID_VALUE, default 32'h1C0A0001, value returned by the ID register.
REQ-002 The block SHALL have parameter DPRAM_AW, default 10, width of the ADC DPRAM read address.
REQ-003 The block SHALL have parameter RST_CYCLES, default 16, length in clk cycles of every software reset pulse.
REQ-004 The block SHALL have port clk  in  1  system clock; the only clock in the block.
REQ-005 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port addr  in  7  register address from spi_slave.
REQ-007 The block SHALL have port data_out  in  32  write data from spi_slave.
REQ-008 The block SHALL have port data_in  out  32  read data to spi_slave.
REQ-009 The block SHALL have ports wr_en / rd_en  in  1  one-clk write / read strobes from spi_slave.
REQ-010 The block SHALL have ports irq_src  in  8  (event lines) and irq  out  1  (interrupt request).
REQ-011 The block SHALL have port sw_rst  out  8  software reset lines.
REQ-012 The block SHALL have port led  out  4  LED drive.
REQ-013 The block SHALL have ports dpram_rd_addr  out  DPRAM_AW and dpram_rd_data  in  32 (read data valid 1 clk after the address).
REQ-014 The block SHALL have ports dpram_ctrl  out  8, ddc_ctrl  out  32, ddc_lo_freq  out  32 and i2s_mux_sel  out  2.

Function
REQ-015 Register map SHALL be:
- 0x00 ID: RO.
- 0x01 RST_CNTRL.
- 0x02 IRQ_CNTRL_STATUS.
- 0x03 LED_CNTRL [3:0].
- 0x10 ADC_DPRAM_CNTRL [7:0].
- 0x11 ADC_DPRAM_ADDR [DPRAM_AW-1:0].
- 0x12 ADC_DPRAM_DATA: RO.
- 0x20 DDC_CNTRL [31:0].
- 0x21 DDC_LO_FREQ [31:0].
- 0x30 AUDIO_I2S_MUX_SEL [1:0].
REQ-016 data_in SHALL be combinational from addr and current register state, zero-extended; unmapped addresses SHALL read 0.
REQ-017 A write SHALL update the addressed register on the clk edge where wr_en=1; writes to RO or unmapped addresses SHALL be ignored.
REQ-018 If wr_en and rd_en are both 1, the write SHALL take effect and the read side effects SHALL be suppressed.
REQ-019 A RST_CNTRL write SHALL assert each sw_rst bit whose written bit is 1 for exactly RST_CYCLES cycles, starting the cycle after the write.
REQ-020 A RST_CNTRL rewrite of an active bit SHALL restart that bit's count; reads SHALL return the currently asserted sw_rst bits.
REQ-021 IRQ bits [7:0] (status) SHALL be set on a rising edge of the corresponding irq_src bit, using registered edge detection.
REQ-022 Writing 1 to an IRQ status bit SHALL clear it (W1C); an edge in the same cycle as the clear SHALL win.
REQ-023 IRQ bits [15:8] SHALL be RW enables.
REQ-024 irq SHALL be registered OR of (status & enable), 1 clk latency.
REQ-025 dpram_rd_addr SHALL equal ADC_DPRAM_ADDR.
REQ-026 ADC_DPRAM_DATA reads SHALL return dpram_rd_data; spi_slave presents addr at least 2 clk before rd_en, which covers the DPRAM latency.
REQ-027 On rd_en at 0x12 with ADC_DPRAM_CNTRL[0] (auto-increment) set, ADC_DPRAM_ADDR SHALL increment by 1, wrapping 2^DPRAM_AW-1 -> 0.
REQ-028 dpram_ctrl, ddc_ctrl, ddc_lo_freq, led and i2s_mux_sel SHALL be direct registered copies of their registers.

Reset
REQ-029 On reset, all registers, edge-detect flops, pulse counters, irq and sw_rst SHALL go to 0 immediately, independent of clk.
REQ-030 Reset mid-pulse SHALL abort sw_rst pulses, with no resumption after release.
REQ-031 ID SHALL read ID_VALUE at all times.

Structure
REQ-032 Register address localparams (CNTRL_SPI_REG_*) and the ID default SHALL live in shared package cntrl_spi_pkg, also used by spi_slave users.
REQ-033 The per-bit RST_CYCLES counter SHALL be sub-module pulse_stretch, instantiated 8 times.

Verification
REQ-034 The bench SHALL cover: write 0x0000_0005 to 0x01 -> sw_rst[0] and sw_rst[2] high for exactly 16 clk, other bits low; read 0x01 during the pulse -> 0x05.
REQ-035 The bench SHALL cover: enable 0x02 = 0x0100, rising edge on irq_src[0] -> status bit 0 set, irq high 1 clk later; write 0x0001 to 0x02 -> irq low; edge coinciding with the clear -> bit stays set.
REQ-036 The bench SHALL cover: 0x10 = 1, 0x11 = 0x3FE, three reads of 0x12 -> data of DPRAM words 0x3FE, 0x3FF, 0x000; address reads 0x001 afterwards.
REQ-037 The bench SHALL cover: write 0xDDC0AA0C to 0x20, then read 0x20 -> 0xDDC0AA0C and ddc_ctrl equal to it; write to 0x00 and to 0x7F -> ID unchanged, 0x7F reads 0.
REQ-038 The bench SHALL cover: assert reset during an sw_rst pulse and with irq high -> all outputs 0 without a clk edge; after release, no pulse resumes.
